array_sequencer: RTL and testbench

Command sequencer directly upstream of `pe_array`. Buffers a host-supplied program of array instructions (command, shift direction, repeat count) in a small FIFO. Replays each instruction to the array over the `command_to_execute` / `shift_direction` / `array_ack` interface, stepping only when the array signals `ready`. Reports busy/done status and a running count of completed array operations.

---
 rtl/pe_array_pkg.sv | 28 ++
 rtl/instr_fifo.sv | 55 +++++
 rtl/array_sequencer.sv | 167 ++++++++++++++++
 tb/tb_array_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array and its command sequencer.
package pe_array_pkg;

    // Command word width shared with pe_array.
    localparam int PE_COMMAND_WIDTH = 4;

    // Command value presented while no operation is being driven.
    localparam logic [PE_COMMAND_WIDTH-1:0] PE_CMD_NOP = 4'd0;

    // Shift-direction encodings understood by the array.
    typedef enum logic [1:0] {
        SHIFT_NORTH = 2'd0,
        SHIFT_EAST  = 2'd1,
        SHIFT_SOUTH = 2'd2,
        SHIFT_WEST  = 2'd3
    } shift_dir_e;

    // Sequencer control states.
    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_FETCH = 3'd1,
        SEQ_ISSUE = 3'd2,
        SEQ_WAIT  = 3'd3,
        SEQ_ACK   = 3'd4,
        SEQ_DONE  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Single-clock instruction FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without an occupancy counter. The head entry
// is visible on pop_data whenever the FIFO is non-empty.
module instr_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_en_s;
    logic             pop_en_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign push_en_s = push && !full;
    assign pop_en_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointer update; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/array_sequencer.sv
// Command sequencer in front of pe_array: buffers host instructions and
// replays each one (repeat+1 times) over the ready/ack handshake.
module array_sequencer
    import pe_array_pkg::*;
#(
    parameter int                       COMMAND_WIDTH = PE_COMMAND_WIDTH,
    parameter int                       REPEAT_WIDTH  = 8,
    parameter int                       FIFO_DEPTH    = 8,
    parameter logic [COMMAND_WIDTH-1:0] CMD_NOP       = COMMAND_WIDTH'(PE_CMD_NOP)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [COMMAND_WIDTH-1:0] instr_command,
    input  logic [1:0]               instr_shift,
    input  logic [REPEAT_WIDTH-1:0]  instr_repeat,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     array_ready,
    output logic                     array_ack,
    output logic [COMMAND_WIDTH-1:0] command_to_execute,
    output logic [1:0]               shift_direction,
    output logic [15:0]              ops_issued
);

    localparam int ENTRY_W = COMMAND_WIDTH + 2 + REPEAT_WIDTH;

    seq_state_e                 state_r;
    seq_state_e                 state_next_s;
    logic [COMMAND_WIDTH-1:0]   cur_cmd_r;
    logic [COMMAND_WIDTH-1:0]   cur_cmd_next_s;
    logic [1:0]                 cur_shift_r;
    logic [1:0]                 cur_shift_next_s;
    logic [REPEAT_WIDTH-1:0]    rep_cnt_r;
    logic [REPEAT_WIDTH-1:0]    rep_cnt_next_s;
    logic [15:0]                ops_r;
    logic [15:0]                ops_next_s;
    logic                       busy_r;
    logic                       done_r;
    logic                       ack_r;
    logic [COMMAND_WIDTH-1:0]   cmd_out_r;
    logic [COMMAND_WIDTH-1:0]   cmd_out_next_s;

    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic                       fifo_pop_s;
    logic                       fifo_push_s;
    logic [ENTRY_W-1:0]         fifo_wr_data_s;
    logic [ENTRY_W-1:0]         fifo_rd_data_s;

    assign fifo_push_s    = instr_valid;
    assign fifo_wr_data_s = {instr_command, instr_shift, instr_repeat};

    instr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (fifo_push_s),
        .push_data (fifo_wr_data_s),
        .full      (fifo_full_s),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_rd_data_s),
        .empty     (fifo_empty_s)
    );

    // Next-state, datapath and next-output decode for the sequencer FSM.
    always_comb begin
        state_next_s     = state_r;
        cur_cmd_next_s   = cur_cmd_r;
        cur_shift_next_s = cur_shift_r;
        rep_cnt_next_s   = rep_cnt_r;
        fifo_pop_s       = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                if (start) begin
                    state_next_s = fifo_empty_s ? SEQ_DONE : SEQ_FETCH;
                end else begin
                    state_next_s = SEQ_IDLE;
                end
            end
            SEQ_FETCH: begin
                fifo_pop_s = 1'b1;
                {cur_cmd_next_s, cur_shift_next_s, rep_cnt_next_s} = fifo_rd_data_s;
                state_next_s = SEQ_ISSUE;
            end
            SEQ_ISSUE: begin
                // The array's ready is deliberately not looked at here.
                state_next_s = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (array_ready) begin
                    state_next_s = SEQ_ACK;
                end else begin
                    state_next_s = SEQ_WAIT;
                end
            end
            SEQ_ACK: begin
                if (rep_cnt_r != {REPEAT_WIDTH{1'b0}}) begin
                    rep_cnt_next_s = rep_cnt_r - {{(REPEAT_WIDTH-1){1'b0}}, 1'b1};
                    state_next_s   = SEQ_ISSUE;
                end else if (!fifo_empty_s) begin
                    state_next_s = SEQ_FETCH;
                end else begin
                    state_next_s = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                state_next_s = SEQ_IDLE;
            end
            default: begin
                state_next_s = SEQ_IDLE;
            end
        endcase

        if (state_next_s == SEQ_ACK) begin
            ops_next_s = ops_r + 16'd1;
        end else begin
            ops_next_s = ops_r;
        end

        if ((state_next_s == SEQ_ISSUE) || (state_next_s == SEQ_WAIT)) begin
            cmd_out_next_s = cur_cmd_next_s;
        end else begin
            cmd_out_next_s = CMD_NOP;
        end
    end

    // State, working registers and registered outputs; outputs are loaded
    // from the next-state decode so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= SEQ_IDLE;
            cur_cmd_r   <= CMD_NOP;
            cur_shift_r <= 2'd0;
            rep_cnt_r   <= {REPEAT_WIDTH{1'b0}};
            ops_r       <= 16'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ack_r       <= 1'b0;
            cmd_out_r   <= CMD_NOP;
        end else begin
            state_r     <= state_next_s;
            cur_cmd_r   <= cur_cmd_next_s;
            cur_shift_r <= cur_shift_next_s;
            rep_cnt_r   <= rep_cnt_next_s;
            ops_r       <= ops_next_s;
            busy_r      <= (state_next_s != SEQ_IDLE);
            done_r      <= (state_next_s == SEQ_DONE);
            ack_r       <= (state_next_s == SEQ_ACK);
            cmd_out_r   <= cmd_out_next_s;
        end
    end

    assign instr_ready        = !fifo_full_s;
    assign busy               = busy_r;
    assign done               = done_r;
    assign array_ack          = ack_r;
    assign command_to_execute = cmd_out_r;
    // cur_shift only changes at a fetch, so the last direction is held between operations.
    assign shift_direction    = cur_shift_r;
    assign ops_issued         = ops_r;

endmodule

// File: tb/tb_array_sequencer.sv
// Scoreboard bench for array_sequencer: instruction pushes enqueue the
// expected operations; a negedge monitor checks each array_ack against them.
module tb_array_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_command = 4'd0;
    logic [1:0]  instr_shift = 2'd0;
    logic [7:0]  instr_repeat = 8'd0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        array_ready = 1'b1;
    logic        array_ack;
    logic [3:0]  command_to_execute;
    logic [1:0]  shift_direction;
    logic [15:0] ops_issued;

    typedef struct {
        logic [3:0] cmd;
        logic [1:0] shift;
        int         hold;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_err = 0;
    int ready_delay = 0;
    int run_has_ops = 0;
    int ack_total = 0;
    int cnt = 0;
    int prev_ack = 0;
    logic [3:0] last_cmd = 4'd0;

    array_sequencer dut (
        .CLK                (CLK),
        .RST                (RST),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .instr_command      (instr_command),
        .instr_shift        (instr_shift),
        .instr_repeat       (instr_repeat),
        .start              (start),
        .busy               (busy),
        .done               (done),
        .array_ready        (array_ready),
        .array_ack          (array_ack),
        .command_to_execute (command_to_execute),
        .shift_direction    (shift_direction),
        .ops_issued         (ops_issued)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Push one instruction and enqueue its repeat+1 expected operations.
    task automatic push_instr(input int c, input int s, input int r);
        exp_t e;
        instr_valid   = 1'b1;
        instr_command = 4'(c);
        instr_shift   = 2'(s);
        instr_repeat  = 8'(r);
        e.cmd   = 4'(c);
        e.shift = 2'(s);
        e.hold  = (ready_delay == 0) ? 2 : ready_delay + 1;
        for (int k = 0; k <= r; k++) exp_q.push_back(e);
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int got;
        got = 0;
        for (int k = 0; k < bound; k++) begin
            if (done) begin
                got = 1;
                break;
            end
            tick();
        end
        check(name, got, 1);
        tick();
        check({name, "_idle"}, busy, 0);
    endtask

    // Monitor and array model: counts presentation cycles, raises ready after
    // the configured delay, and scores every ack against the queue.
    always @(negedge CLK) begin
        if (RST) begin
            cnt = 0;
            prev_ack = 0;
            last_cmd = 4'd0;
            array_ready = (ready_delay == 0);
        end else begin
            if (array_ack) begin
                ack_total++;
                check("ack_cmd_nop", command_to_execute, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_cmd", last_cmd, mon_e.cmd);
                    check("ack_shift", shift_direction, mon_e.shift);
                    check("wait_hold", cnt, mon_e.hold);
                end
            end
            if (done && (run_has_ops != 0)) check("done_after_ack", prev_ack, 1);
            prev_ack = array_ack;
            if (array_ack || (command_to_execute == 4'd0)) begin
                cnt = 0;
            end else begin
                cnt++;
                last_cmd = command_to_execute;
            end
            array_ready = (ready_delay == 0) || (cnt >= ready_delay + 1);
        end
    end

    initial begin
        int a0;
        int got;
        // Reset values
        tick(); tick();
        RST = 1'b0;
        check("rst_instr_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack", array_ack, 0);
        check("rst_cmd", command_to_execute, 0);
        check("rst_shift", shift_direction, 0);
        check("rst_ops", ops_issued, 0);

        // Start with empty FIFO: done without any operation
        run_has_ops = 0;
        pulse_start();
        check("empty_done", done, 1);
        check("empty_ops", ops_issued, 0);
        tick();
        check("empty_done_clear", done, 0);
        check("empty_busy_clear", busy, 0);

        // Single instruction, ready tied high
        ready_delay = 0;
        push_instr(3, 2, 0);
        run_has_ops = 1;
        a0 = ack_total;
        pulse_start();
        check("single_fetch_nop", command_to_execute, 0);
        tick();
        check("single_cmd_latency", command_to_execute, 3);
        check("single_shift", shift_direction, 2);
        wait_done(50, "single_done");
        check("single_ops", ops_issued, 1);
        check("single_acks", ack_total - a0, 1);

        // Repeat 2 with ready delayed 4 cycles
        ready_delay = 4;
        push_instr(5, 1, 2);
        a0 = ack_total;
        pulse_start();
        wait_done(100, "rep_done");
        check("rep_ops", ops_issued, 4);
        check("rep_acks", ack_total - a0, 3);
        check("rep_shift_held", shift_direction, 1);

        // Fill the FIFO, then a dropped ninth push
        ready_delay = 0;
        for (int i = 1; i <= 8; i++) push_instr(i, i % 4, 0);
        check("full_not_ready", instr_ready, 0);
        instr_valid = 1'b1;
        instr_command = 4'd9;
        instr_shift = 2'd3;
        instr_repeat = 8'd0;
        tick();
        instr_valid = 1'b0;
        check("full_still_not_ready", instr_ready, 0);
        a0 = ack_total;
        pulse_start();
        wait_done(200, "fill_done");
        check("fill_ops", ops_issued, 12);
        check("fill_acks", ack_total - a0, 8);
        check("fill_queue_empty", exp_q.size(), 0);

        // Reset while waiting with three entries queued
        ready_delay = 50;
        push_instr(6, 1, 0);
        push_instr(7, 2, 0);
        push_instr(8, 3, 0);
        pulse_start();
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (command_to_execute == 4'd6) begin
                got = 1;
                break;
            end
            tick();
        end
        check("rstw_reached_wait", got, 1);
        tick(); tick();
        RST = 1'b1;
        exp_q.delete();
        tick();
        RST = 1'b0;
        check("rstw_busy", busy, 0);
        check("rstw_ack", array_ack, 0);
        check("rstw_cmd", command_to_execute, 0);
        check("rstw_ops", ops_issued, 0);
        check("rstw_instr_ready", instr_ready, 1);
        ready_delay = 0;
        tick();
        run_has_ops = 0;
        pulse_start();
        check("rstw_immediate_done", done, 1);
        tick();
        check("rstw_ops_after", ops_issued, 0);

        // Push while the last instruction is in WAIT
        run_has_ops = 1;
        ready_delay = 4;
        push_instr(7, 3, 0);
        a0 = ack_total;
        pulse_start();
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (command_to_execute == 4'd7) begin
                got = 1;
                break;
            end
            tick();
        end
        check("late_reached_cmd", got, 1);
        push_instr(9, 1, 1);
        wait_done(100, "late_done");
        check("late_ops", ops_issued, 3);
        check("late_acks", ack_total - a0, 3);

        // Maximum repeat count: 256 operations
        ready_delay = 0;
        push_instr(4, 3, 255);
        a0 = ack_total;
        pulse_start();
        wait_done(2000, "maxrep_done");
        check("maxrep_ops", ops_issued, 259);
        check("maxrep_acks", ack_total - a0, 256);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
